md_unit_ctrl: RTL and testbench
===============================

// Module: md_unit_ctrl
// PURPOSE
//   Sequencer for the multiply/divide unit in the E stage. Accepts mult/multu/div/divu/mthi/mtlo from E.
//   Computes the HI/LO result and holds the unit busy for a fixed latency.
//   Drives the start/busy pair that the hazard unit uses to stall MD instructions in D.
//   Also provides HI/LO read data for mfhi/mflo.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles after a mult/multu start (>=1)
//   DIV_CYCLES   10  busy cycles after a div/divu start (>=1, >=MULT_CYCLES)
// PORTS
//   clk       in   1   single clock, rising edge
//   reset     in   1   asynchronous, active-low reset
//   md_op     in   3   E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 rsvd (=none)
//   src_a     in   32  forwarded rs value from E (nRS_E)
//   src_b     in   32  forwarded rt value from E (nRT_E)
//   start     out  1   combinational: md_op is mult/multu/div/divu and state is IDLE
//   busy      out  1   registered: operation in flight
//   hi        out  32  HI register
//   lo        out  32  LO register
// BEHAVIOUR
//   Reset: state IDLE, busy=0, hi=0, lo=0, counter=0, pending result=0. start is 0 while md_op=0.
//   IDLE, start cycle T:
//     - latch 64-bit result into pending_hi/lo
//     - load counter with N-1 (N = MULT_CYCLES or DIV_CYCLES); go BUSY
//   BUSY: busy=1 during cycles T+1..T+N; counter decrements each cycle.
//     - Cycle with counter==0: hi/lo <= pending (visible T+N+1); go IDLE
//     - busy=0 from T+N+1; a new start is accepted in cycle T+N+1
//   mthi/mtlo in IDLE: hi<=src_a / lo<=src_a at end of the same cycle; no busy.
//   Any op presented while BUSY: ignored, no state change; assertion fires (the hazard unit guarantees it never happens).
//   mult: signed 64-bit product, hi=[63:32], lo=[31:0]. multu: unsigned.
//   div: signed, quotient truncated toward zero -> lo, remainder with sign of dividend -> hi.
//   0x80000000 div 0xFFFFFFFF: lo=0x80000000, hi=0.
//   divu: unsigned quotient -> lo, remainder -> hi.
//   Divide by zero (src_b==0): busy sequence runs normally; hi/lo left unchanged at completion.
//   Reset mid-operation: immediately IDLE, busy=0, hi/lo=0, pending discarded.
//   Counter width: $clog2(DIV_CYCLES+1); it never wraps.
// CONFIGURATION
//   MDU_CANCEL_EN defined:
//     - adds input `cancel` (1 bit, exception/flush from M)
//     - cancel=1 while BUSY: go IDLE next cycle, busy=0, hi/lo not written, pending discarded
//     - cancel=1 in IDLE: suppresses start and a same-cycle mthi/mtlo write
//   MDU_CANCEL_EN undefined: no cancel port; every started op always commits.
// STRUCTURE
//   package mdu_pkg:
//     - md_op codes (MD_NONE..MD_MTLO)
//     - state encoding (ST_IDLE, ST_BUSY)
//     - default cycle constants
//   sub-module mdu_arith: purely combinational; (md_op, src_a, src_b) -> {res_hi, res_lo, div_by_zero}.
//   md_unit_ctrl holds FSM, counter, pending and HI/LO registers.
// TESTING
//   1 mult a=0xFFFFFFFE(-2) b=3 at T:
//     - start=1 at T; busy=1 for T+1..T+5
//     - hi=0xFFFFFFFF, lo=0xFFFFFFFA at T+6
//   2 multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
//   3 div a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
//     divu a=7 b=0 -> busy 10 cycles, hi/lo unchanged.
//   4 mtlo a=0x12345678 in IDLE -> lo=0x12345678 next cycle, busy stays 0;
//     mult issued in the cycle busy falls -> accepted (start=1).
//   5 reset asserted at busy cycle 3 of a div -> busy=0, hi=lo=0 immediately;
//     no write after reset deasserts.
//   6 (MDU_CANCEL_EN) cancel at busy cycle 2 of mult 3*4 -> busy=0 next cycle, lo keeps its prior value.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state encoding and default latencies for the multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_RSVD  = 3'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_md_start(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO datapath: 64-bit products and 32-bit quotient/remainder.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  md_op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o,
    output logic        div_by_zero_o
);

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] a_s, dvs_s, quo_s, rem_s;
    logic [31:0]        dvs_u, quo_u, rem_u;
    logic               b_zero, s_ovf;

    always_comb begin
        a_sx   = {{32{src_a_i[31]}}, src_a_i};
        b_sx   = {{32{src_b_i[31]}}, src_b_i};
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, src_a_i} * {32'd0, src_b_i};

        b_zero = (src_b_i == 32'd0);
        s_ovf  = (src_a_i == 32'h8000_0000) && (src_b_i == 32'hFFFF_FFFF);

        // Divisors are forced to 1 on the zero and overflow cases so the
        // divider never sees an undefined operation; those results are muxed.
        a_s   = src_a_i;
        dvs_s = (b_zero || s_ovf) ? 32'sd1 : src_b_i;
        quo_s = a_s / dvs_s;
        rem_s = a_s % dvs_s;
        dvs_u = b_zero ? 32'd1 : src_b_i;
        quo_u = src_a_i / dvs_u;
        rem_u = src_a_i % dvs_u;

        res_hi_o      = 32'd0;
        res_lo_o      = 32'd0;
        div_by_zero_o = 1'b0;
        case (md_op_i)
            MD_MULT: begin
                res_hi_o = prod_s[63:32];
                res_lo_o = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi_o = prod_u[63:32];
                res_lo_o = prod_u[31:0];
            end
            MD_DIV: begin
                div_by_zero_o = b_zero;
                res_hi_o      = s_ovf ? 32'd0 : rem_s;
                res_lo_o      = s_ovf ? 32'h8000_0000 : quo_s;
            end
            MD_DIVU: begin
                div_by_zero_o = b_zero;
                res_hi_o      = rem_u;
                res_lo_o      = quo_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer: start/busy handshake, latency counter, HI/LO registers.
// Optional MDU_CANCEL_EN adds a cancel_i input that aborts in-flight ops and same-cycle writes.
//
// state   | meaning
// ST_IDLE | accepts mult/div starts and mthi/mtlo writes
// ST_BUSY | op in flight, counter runs down, result commits when it reaches 0
module md_unit_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  md_op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
`ifdef MDU_CANCEL_EN
    input  logic        cancel_i,
`endif
    output logic        start_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic          pend_dz_q, pend_dz_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   res_hi, res_lo;
    logic          res_dz;
    logic          cancel_w;

`ifdef MDU_CANCEL_EN
    assign cancel_w = cancel_i;
`else
    assign cancel_w = 1'b0;
`endif

    mdu_arith u_arith (
        .md_op_i      (md_op_i),
        .src_a_i      (src_a_i),
        .src_b_i      (src_b_i),
        .res_hi_o     (res_hi),
        .res_lo_o     (res_lo),
        .div_by_zero_o(res_dz)
    );

    assign start_o = (state_q == ST_IDLE) && is_md_start(md_op_i) && !cancel_w;
    assign busy_o  = (state_q == ST_BUSY);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_o) begin
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    pend_dz_d = res_dz;
                    cnt_d     = is_div(md_op_i) ? DIV_LOAD : MULT_LOAD;
                    state_d   = ST_BUSY;
                end else if (!cancel_w && md_op_i == MD_MTHI) begin
                    hi_d = src_a_i;
                end else if (!cancel_w && md_op_i == MD_MTLO) begin
                    lo_d = src_a_i;
                end
            end
            ST_BUSY: begin
                if (cancel_w) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    pend_hi_d = 32'd0;
                    pend_lo_d = 32'd0;
                    pend_dz_d = 1'b0;
                end else if (cnt_q == '0) begin
                    // A divide by zero still runs the full latency but leaves HI/LO alone.
                    if (!pend_dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // The hazard unit stalls MD ops in D while busy, so none should reach E then.
    a_no_op_while_busy: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (state_q == ST_BUSY) |-> (md_op_i == MD_NONE || md_op_i == MD_RSVD));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: directed cases plus random ops against an arithmetic reference model.
module tb_md_unit_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  md_op;
    logic [31:0] src_a, src_b;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif
    logic        start, busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .md_op_i (md_op),
        .src_a_i (src_a),
        .src_b_i (src_b),
`ifdef MDU_CANCEL_EN
        .cancel_i(cancel),
`endif
        .start_o (start),
        .busy_o  (busy),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int op_cycles(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MC;
        if (op == 3'd3 || op == 3'd4) return DC;
        return 0;
    endfunction

    // Reference: what HI/LO hold once the op has completed.
    function automatic void model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ma, mb, q, r, p;
        longint unsigned ua, ub, pu;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin pu = ua * ub; m_hi = pu[63:32]; m_lo = pu[31:0]; end
            3'd3: if (b != 32'd0) begin
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                q  = ma / mb;
                r  = ma % mb;
                if ((sa < 0) != (sb < 0)) q = -q;
                if (sa < 0) r = -r;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            3'd4: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] old_hi, old_lo;
        n = op_cycles(op);
        old_hi = m_hi;
        old_lo = m_lo;
        check({tag, ".idle"}, 32'(busy), 32'd0);
        md_op = op; src_a = a; src_b = b;
        #1;
        check({tag, ".start"}, 32'(start), (n > 0) ? 32'd1 : 32'd0);
        model_apply(op, a, b);
        @(posedge clk); #1;
        md_op = 3'd0; src_a = $urandom; src_b = $urandom;
        for (int i = 1; i <= n; i++) begin
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".start_busy"}, 32'(start), 32'd0);
            check({tag, ".hi_hold"}, hi, old_hi);
            check({tag, ".lo_hold"}, lo, old_lo);
            @(posedge clk); #1;
        end
        check({tag, ".done"}, 32'(busy), 32'd0);
        check({tag, ".hi"}, hi, m_hi);
        check({tag, ".lo"}, lo, m_lo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;

        rst_n = 1'b0; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.start", 32'(start), 32'd0);
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("t1.mult", 3'd1, 32'hFFFF_FFFE, 32'd3);
        check("t1.hi_const", hi, 32'hFFFF_FFFF);
        check("t1.lo_const", lo, 32'hFFFF_FFFA);
        run_op("t2.multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("t2.hi_const", hi, 32'hFFFF_FFFE);
        check("t2.lo_const", lo, 32'h0000_0001);
        run_op("t3.div", 3'd3, 32'hFFFF_FFF9, 32'd2);
        check("t3.hi_const", hi, 32'hFFFF_FFFF);
        check("t3.lo_const", lo, 32'hFFFF_FFFD);
        run_op("t3.divu0", 3'd4, 32'd7, 32'd0);
        run_op("t4.mtlo", 3'd6, 32'h1234_5678, 32'd0);
        check("t4.lo_const", lo, 32'h1234_5678);
        run_op("t4.mult_b2b", 3'd1, 32'd1000, 32'hFFFF_FFF0);
        run_op("ovf.div", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf.lo_const", lo, 32'h8000_0000);
        check("ovf.hi_const", hi, 32'd0);
        run_op("mthi", 3'd5, 32'hCAFE_F00D, 32'd0);
        run_op("rsvd", 3'd7, 32'hDEAD_BEEF, 32'd5);

        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(1, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            if ((op == 3'd3 || op == 3'd4) && $urandom_range(0, 5) == 0) b = 32'd0;
            run_op("rand", op, a, b);
        end

        // Reset in the third busy cycle of a divide.
        run_op("t5.pre_hi", 3'd5, 32'h5555_AAAA, 32'd0);
        run_op("t5.pre_lo", 3'd6, 32'hAAAA_5555, 32'd0);
        md_op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        #1 check("t5.start", 32'(start), 32'd1);
        @(posedge clk); #1;
        md_op = 3'd0;
        for (int i = 1; i <= 3; i++) begin
            check("t5.busy", 32'(busy), 32'd1);
            if (i < 3) begin @(posedge clk); #1; end
        end
        rst_n = 1'b0;
        #1;
        check("t5.busy_rst", 32'(busy), 32'd0);
        check("t5.hi_rst", hi, 32'd0);
        check("t5.lo_rst", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (DC + 2) @(posedge clk);
        #1;
        check("t5.busy_after", 32'(busy), 32'd0);
        check("t5.hi_after", hi, 32'd0);
        check("t5.lo_after", lo, 32'd0);

`ifdef MDU_CANCEL_EN
        run_op("t6.pre_lo", 3'd6, 32'h0BAD_CAFE, 32'd0);
        md_op = 3'd1; src_a = 32'd3; src_b = 32'd4;
        #1 check("t6.start", 32'(start), 32'd1);
        @(posedge clk); #1;
        md_op = 3'd0;
        check("t6.busy1", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("t6.busy2", 32'(busy), 32'd1);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("t6.busy_cancel", 32'(busy), 32'd0);
        check("t6.lo_cancel", lo, m_lo);
        repeat (MC + 2) @(posedge clk);
        #1;
        check("t6.lo_later", lo, m_lo);
        check("t6.hi_later", hi, m_hi);
        cancel = 1'b1; md_op = 3'd6; src_a = 32'h7777_7777;
        #1 check("t6.start_sup", 32'(start), 32'd0);
        @(posedge clk); #1;
        cancel = 1'b0; md_op = 3'd0;
        check("t6.mtlo_sup", lo, m_lo);
        check("t6.idle_sup", 32'(busy), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
